// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the 1-to-4 result router: channel count, select
// type and small helpers for decoding a select code and locating a
// channel's slice inside a packed multi-channel bus.
// Optional feature macro used by the router top: DEMUX_STATS_EN.
// ---------------------------------------------------------------------------
package demux_pkg;

   localparam int CH_NUM = 4;
   localparam int SEL_W  = 2;

   typedef logic [SEL_W-1:0]  sel_t;
   typedef logic [CH_NUM-1:0] ch_mask_t;

   // Turn a select code into a one-hot channel mask.
   function automatic ch_mask_t sel_to_onehot(input sel_t sel);
      ch_mask_t mask;
      mask      = '0;
      mask[sel] = 1'b1;
      return mask;
   endfunction

   // Bit position of the least significant bit of channel ch in a bus
   // built from CH_NUM slices of w bits each.
   function automatic int chan_lsb(input int ch, input int w);
      return ch * w;
   endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// ---------------------------------------------------------------------------
// demux_chan_reg
// One-entry holding register for a single output channel of the router.
// A word is loaded on push and stays visible until the consumer pops it.
// Push and pop in the same cycle replace the word without a bubble.
//
// Ports
//   clk      in   1   clock, all state on posedge
//   rst      in   1   synchronous active-high reset, empties the register
//   push_i   in   1   load data_i this cycle (caller only pushes when ready_o)
//   pop_i    in   1   consumer ready; removes the held word if valid
//   data_i   in   W   word to load
//   valid_o  out  1   register holds a word
//   ready_o  out  1   register can take a word this cycle
//   data_o   out  W   held word (keeps last value while empty)
// ---------------------------------------------------------------------------
module demux_chan_reg #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic         ready_o,
   output logic [W-1:0] data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q,  data_d;

   // Next-state for the holding register. A pop empties the slot, and a
   // push in the same cycle refills it, so push is applied after pop.
   // Data is only written on push, which keeps a drained word visible and
   // keeps don't-care input data out of the register.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (valid_q && pop_i) begin
         valid_d = 1'b0;
      end
      if (push_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   // The slot can take a word when it is empty or when its current word
   // is leaving this same cycle.
   assign ready_o = !valid_q || pop_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/demux1to4_router.sv
// ---------------------------------------------------------------------------
// demux1to4_router
// Receiving end of the 4:1 arithmetic result mux. One W-bit result stream,
// tagged with a 2-bit select, is routed into one of four one-entry output
// channels with valid/ready handshakes. A stalled channel only blocks words
// addressed to itself.
//
// Optional feature macro: DEMUX_STATS_EN
//   defined   -> per-channel saturating accepted-word counters on xfer_cnt
//   undefined -> no counters, no xfer_cnt port, identical routing
//
// Ports
//   clk         in   1        clock, all logic on posedge
//   rst         in   1        synchronous active-high reset
//   enable_low  in   1        active-low enable, 1 blocks new input words
//   in_valid    in   1        input word valid
//   in_ready    out  1        input accepted when in_valid && in_ready
//   in_sel      in   2        destination channel 0..3
//   in_data     in   W        result word
//   out_valid   out  4        per-channel holding register full
//   out_ready   in   4        per-channel consumer ready
//   out_data    out  4*W      channel k at [k*W +: W]
//   xfer_cnt    out  4*CNT_W  channel k count at [k*CNT_W +: CNT_W]
//                             (DEMUX_STATS_EN only)
// ---------------------------------------------------------------------------
module demux1to4_router
   import demux_pkg::*;
#(
   parameter int W = 16
`ifdef DEMUX_STATS_EN
   , parameter int CNT_W = 8
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable_low,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          in_sel,
   input  logic [W-1:0]        in_data,
   output logic [CH_NUM-1:0]   out_valid,
   input  logic [CH_NUM-1:0]   out_ready,
   output logic [CH_NUM*W-1:0] out_data
`ifdef DEMUX_STATS_EN
   , output logic [CH_NUM*CNT_W-1:0] xfer_cnt
`endif
);

   ch_mask_t selMask;
   ch_mask_t chanReady;
   ch_mask_t pushMask;
   logic     selReady;
   logic     accept;

   // Input side: decode the select and pick that channel's readiness.
   // in_ready never looks at in_valid and reads 0 throughout reset so no
   // handshake can complete in a reset cycle.
   always_comb begin
      selMask  = sel_to_onehot(sel_t'(in_sel));
      selReady = chanReady[in_sel];
      in_ready = !rst && !enable_low && selReady;
      accept   = in_valid && in_ready;
      pushMask = accept ? selMask : '0;
   end

   // One holding register per channel.
   for (genvar k = 0; k < CH_NUM; k++) begin : g_chan
      demux_chan_reg #(
         .W(W)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .push_i  (pushMask[k]),
         .pop_i   (out_ready[k]),
         .data_i  (in_data),
         .valid_o (out_valid[k]),
         .ready_o (chanReady[k]),
         .data_o  (out_data[chan_lsb(k, W) +: W])
      );
   end

`ifdef DEMUX_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   for (genvar k = 0; k < CH_NUM; k++) begin : g_stats
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Count accepted words for this channel, holding at the top value
      // instead of wrapping so a long run never reads as a small count.
      always_comb begin
         cnt_d = cnt_q;
         if (pushMask[k] && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end

      // Counter register, cleared only by reset.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign xfer_cnt[chan_lsb(k, CNT_W) +: CNT_W] = cnt_q;
   end
`endif

endmodule

// File: tb/tb_demux1to4_router.sv
// ---------------------------------------------------------------------------
// tb_demux1to4_router
// Directed, table-driven bench for the 1-to-4 router. Each table row gives
// the inputs for one cycle, the expected combinational in_ready, and the
// expected out_valid / out_data after the following clock edge. Reset and
// the saturating counters (DEMUX_STATS_EN) are covered by hand sequences.
// ---------------------------------------------------------------------------
module tb_demux1to4_router;

   localparam int NVEC = 22;

   typedef struct {
      logic        enLow;
      logic        inValid;
      logic [1:0]  inSel;
      logic [15:0] inData;
      logic [3:0]  outReady;
      logic        expInReady;
      logic [3:0]  expOutValid;
      logic [63:0] expOutData;
   } vec_t;

   logic        clock;
   logic        reset;
   logic        enableLow;
   logic        inValid;
   logic        inReady;
   logic [1:0]  inSel;
   logic [15:0] inData;
   logic [3:0]  outValid;
   logic [3:0]  outReady;
   logic [63:0] outData;
`ifdef DEMUX_STATS_EN
   logic [31:0] xferCnt;
`endif

   int   testCount;
   int   failCount;
   vec_t vecs [NVEC];

   demux1to4_router #(
      .W(16)
`ifdef DEMUX_STATS_EN
      , .CNT_W(8)
`endif
   ) dut (
      .clk        (clock),
      .rst        (reset),
      .enable_low (enableLow),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .in_sel     (inSel),
      .in_data    (inData),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .out_data   (outData)
`ifdef DEMUX_STATS_EN
      , .xfer_cnt (xferCnt)
`endif
   );

   // Free-running clock, posedge at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic vec_t mkVec(input logic enLow, input logic inValid, input logic [1:0] inSel,
                                  input logic [15:0] inData, input logic [3:0] outReady,
                                  input logic expInReady, input logic [3:0] expOutValid,
                                  input logic [63:0] expOutData);
      vec_t v;
      v.enLow       = enLow;
      v.inValid     = inValid;
      v.inSel       = inSel;
      v.inData      = inData;
      v.outReady    = outReady;
      v.expInReady  = expInReady;
      v.expOutValid = expOutValid;
      v.expOutData  = expOutData;
      return v;
   endfunction

   // Compare one value and record the outcome.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drive one table row (called #1 after a posedge), check the
   // combinational in_ready, then clock and check the registered outputs.
   task automatic applyStimulus(input int idx, input vec_t v);
      enableLow = v.enLow;
      inValid   = v.inValid;
      inSel     = v.inSel;
      inData    = v.inData;
      outReady  = v.outReady;
      #1;
      checkOutput($sformatf("v%0d in_ready", idx), {63'd0, inReady}, {63'd0, v.expInReady});
      @(posedge clock);
      #1;
      checkOutput($sformatf("v%0d out_valid", idx), {60'd0, outValid}, {60'd0, v.expOutValid});
      checkOutput($sformatf("v%0d out_data", idx), outData, v.expOutData);
   endtask

   initial begin
      testCount = 0;
      failCount = 0;

      // en, vld, sel, data, oready, expRdy, expVld, expData {ch3,ch2,ch1,ch0}
      // Routing, all consumers ready: one-hot valid per cycle.
      vecs[0]  = mkVec(0, 1, 2'd0, 16'h0082, 4'b1111, 1, 4'b0001, 64'h0000_0000_0000_0082);
      vecs[1]  = mkVec(0, 1, 2'd1, 16'h007E, 4'b1111, 1, 4'b0010, 64'h0000_0000_007E_0082);
      vecs[2]  = mkVec(0, 1, 2'd2, 16'h0100, 4'b1111, 1, 4'b0100, 64'h0000_0100_007E_0082);
      vecs[3]  = mkVec(0, 1, 2'd3, 16'h0040, 4'b1111, 1, 4'b1000, 64'h0040_0100_007E_0082);
      vecs[4]  = mkVec(0, 0, 2'd0, 16'hDEAD, 4'b1111, 1, 4'b0000, 64'h0040_0100_007E_0082);
      // Channel 2 stalled; channel 1 keeps flowing.
      vecs[5]  = mkVec(0, 1, 2'd2, 16'h0100, 4'b1011, 1, 4'b0100, 64'h0040_0100_007E_0082);
      vecs[6]  = mkVec(0, 1, 2'd2, 16'h1234, 4'b1011, 0, 4'b0100, 64'h0040_0100_007E_0082);
      vecs[7]  = mkVec(0, 1, 2'd1, 16'h00AA, 4'b1011, 1, 4'b0110, 64'h0040_0100_00AA_0082);
      vecs[8]  = mkVec(0, 1, 2'd2, 16'h1234, 4'b1011, 0, 4'b0100, 64'h0040_0100_00AA_0082);
      vecs[9]  = mkVec(0, 1, 2'd2, 16'h1234, 4'b1111, 1, 4'b0100, 64'h0040_1234_00AA_0082);
      vecs[10] = mkVec(0, 0, 2'd2, 16'hBEEF, 4'b1111, 1, 4'b0000, 64'h0040_1234_00AA_0082);
      // Channel 3 simultaneous pop and push.
      vecs[11] = mkVec(0, 1, 2'd3, 16'h0040, 4'b0111, 1, 4'b1000, 64'h0040_1234_00AA_0082);
      vecs[12] = mkVec(0, 1, 2'd3, 16'h0041, 4'b1111, 1, 4'b1000, 64'h0041_1234_00AA_0082);
      vecs[13] = mkVec(0, 0, 2'd3, 16'hBEEF, 4'b0000, 0, 4'b1000, 64'h0041_1234_00AA_0082);
      // Disable with channel 0 full, then drain.
      vecs[14] = mkVec(0, 1, 2'd0, 16'h5555, 4'b0000, 1, 4'b1001, 64'h0041_1234_00AA_5555);
      vecs[15] = mkVec(1, 1, 2'd0, 16'hBEEF, 4'b0000, 0, 4'b1001, 64'h0041_1234_00AA_5555);
      vecs[16] = mkVec(1, 1, 2'd1, 16'hBEEF, 4'b0000, 0, 4'b1001, 64'h0041_1234_00AA_5555);
      vecs[17] = mkVec(1, 1, 2'd2, 16'hBEEF, 4'b0000, 0, 4'b1001, 64'h0041_1234_00AA_5555);
      vecs[18] = mkVec(1, 1, 2'd3, 16'hBEEF, 4'b0000, 0, 4'b1001, 64'h0041_1234_00AA_5555);
      vecs[19] = mkVec(1, 1, 2'd0, 16'hBEEF, 4'b0001, 0, 4'b1000, 64'h0041_1234_00AA_5555);
      vecs[20] = mkVec(1, 1, 2'd3, 16'hBEEF, 4'b1000, 0, 4'b0000, 64'h0041_1234_00AA_5555);
      vecs[21] = mkVec(0, 1, 2'd1, 16'hC0DE, 4'b0000, 1, 4'b0010, 64'h0041_1234_C0DE_5555);

      // Reset held two cycles with a word offered.
      reset     = 1'b1;
      enableLow = 1'b0;
      inValid   = 1'b1;
      inSel     = 2'd2;
      inData    = 16'hFFFF;
      outReady  = 4'b1111;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset in_ready", {63'd0, inReady}, 64'd0);
      checkOutput("reset out_valid", {60'd0, outValid}, 64'd0);
      checkOutput("reset out_data", outData, 64'd0);
`ifdef DEMUX_STATS_EN
      checkOutput("reset xfer_cnt", {32'd0, xferCnt}, 64'd0);
`endif
      reset   = 1'b0;
      inValid = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(i, vecs[i]);
      end

      // Reset with channel 1 full and a word on offer: everything cleared.
      reset     = 1'b1;
      enableLow = 1'b0;
      inValid   = 1'b1;
      inSel     = 2'd1;
      inData    = 16'h7777;
      outReady  = 4'b0000;
      #1;
      checkOutput("midreset in_ready", {63'd0, inReady}, 64'd0);
      @(posedge clock);
      #1;
      checkOutput("midreset out_valid", {60'd0, outValid}, 64'd0);
      checkOutput("midreset out_data", outData, 64'd0);
      reset   = 1'b0;
      inValid = 1'b0;
      #1;
      checkOutput("postreset in_ready", {63'd0, inReady}, 64'd1);

`ifdef DEMUX_STATS_EN
      // 300 back-to-back words to channel 1: counter saturates at 255.
      @(posedge clock);
      #1;
      outReady = 4'b1111;
      inValid  = 1'b1;
      inSel    = 2'd1;
      for (int n = 0; n < 300; n++) begin
         inData = 16'(n);
         @(posedge clock);
         #1;
         if (n == 99) begin
            checkOutput("stats cnt100", {32'd0, xferCnt}, 64'h0000_0000_0000_6400);
         end
      end
      checkOutput("stats cnt300", {32'd0, xferCnt}, 64'h0000_0000_0000_FF00);
      checkOutput("stats ch1 data", outData, 64'h0000_0000_012B_0000);
      // Reset mid-run clears counters and valids in one cycle.
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("stats reset cnt", {32'd0, xferCnt}, 64'd0);
      checkOutput("stats reset valid", {60'd0, outValid}, 64'd0);
      reset   = 1'b0;
      inValid = 1'b0;
`endif

      @(posedge clock);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
